// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin sharing of one combinational ALU between two
//               requesters. Each accepted operation is registered, presented
//               to the ALU for one cycle, and its result and zero flag are
//               returned to the granted requester over a valid/ready
//               handshake. Only one operation is in flight at a time.
// Options     : ALU_ARB_OPCODE_CHECK_EN - when defined, opcodes outside
//               {000,001,010,011,101} are flagged on resp_err and bypass the
//               ALU (result and zero return as 0).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    // Requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [OPW-1:0]   req0_opcode,

    // Requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [OPW-1:0]   req1_opcode,

    // Response channel (shared data, per-requester valid/ready)
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,

    // Shared ALU
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;  // waiting for a request
    localparam logic [1:0] c_ST_EXEC = 2'd1;  // ALU driven from operand regs
    localparam logic [1:0] c_ST_RESP = 2'd2;  // result held for the requester

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    // Arbitration: r_grant is the requester owning the in-flight operation,
    // r_last_grant the requester whose response completed most recently.
    logic             r_grant;
    logic             r_last_grant;
    logic             w_any_req;
    logic             w_sel;
    logic             w_accept;
    logic             w_resp_ready_sel;
    logic             w_release;

    // Selected requester payload
    logic [WIDTH-1:0] w_sel_op1;
    logic [WIDTH-1:0] w_sel_op2;
    logic [OPW-1:0]   w_sel_opcode;

    // Operand registers: the sole source of the ALU inputs
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [OPW-1:0]   r_opcode;

    // Captured response
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    // ------------------------------------------------------------------------
    // Round-robin pick: a lone requester always wins; on contention the
    // requester that was not served last wins. Payload follows the pick.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = req1_valid;
        end
        w_sel_op1    = w_sel ? req1_op1    : req0_op1;
        w_sel_op2    = w_sel ? req1_op2    : req0_op2;
        w_sel_opcode = w_sel ? req1_opcode : req0_opcode;
    end

    assign w_accept         = (r_state == c_ST_IDLE) && w_any_req;
    assign w_resp_ready_sel = r_grant ? resp1_ready : resp0_ready;
    assign w_release        = (r_state == c_ST_RESP) && w_resp_ready_sel;

`ifdef ALU_ARB_OPCODE_CHECK_EN
    // ------------------------------------------------------------------------
    // Opcode legality of the selected request
    // ------------------------------------------------------------------------
    logic w_sel_illegal;
    logic r_illegal;
    logic r_err;

    // Classify the selected opcode against the supported ALU operations
    always_comb begin
        w_sel_illegal = 1'b1;
        case (w_sel_opcode)
            OPW'(0), OPW'(1), OPW'(2), OPW'(3), OPW'(5): w_sel_illegal = 1'b0;
            default:                                     w_sel_illegal = 1'b1;
        endcase
    end
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: accept -> one ALU cycle -> hold until consumed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                w_next_state = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (w_resp_ready_sel) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request ready only while idle, response valid only to owner
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                req0_ready = w_any_req & ~w_sel;
                req1_ready = w_any_req &  w_sel;
            end
            c_ST_RESP: begin
                resp0_valid = ~r_grant;
                resp1_valid =  r_grant;
            end
            default: begin
                req0_ready  = 1'b0;
                req1_ready  = 1'b0;
                resp0_valid = 1'b0;
                resp1_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand capture on acceptance; registers hold until the next accept so
    // the ALU inputs never move outside of an accept edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_opcode <= '0;
            r_grant  <= 1'b0;
        end else if (w_accept) begin
            r_op1    <= w_sel_op1;
            r_op2    <= w_sel_op2;
`ifdef ALU_ARB_OPCODE_CHECK_EN
            // An illegal opcode is replaced by 000 so the ALU never sees it
            r_opcode <= w_sel_illegal ? '0 : w_sel_opcode;
`else
            r_opcode <= w_sel_opcode;
`endif
            r_grant  <= w_sel;
        end
    end

    // Round-robin history advances only when a response is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_release) begin
            r_last_grant <= r_grant;
        end
    end

`ifdef ALU_ARB_OPCODE_CHECK_EN
    // Illegal-opcode tracking: flag set on accept, reported after EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_illegal <= w_sel_illegal;
            end
            if (r_state == c_ST_EXEC) begin
                r_err <= r_illegal;
            end
        end
    end

    // Result capture at the end of EXEC; illegal operations return zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            if (r_illegal) begin
                r_result <= '0;
                r_zero   <= 1'b0;
            end else begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

    assign resp_err = r_err;
`else
    // Result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
        end
    end

    assign resp_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output drives
    // ------------------------------------------------------------------------
    assign alu_operand1 = r_op1;
    assign alu_operand2 = r_op2;
    assign alu_opcode   = r_opcode;
    assign resp_result  = r_result;
    assign resp_zero    = r_zero;

endmodule
`default_nettype wire
